// File: rtl/uart_rec_pkg.sv
// Shared types and widths for the waveform UART record receiver.
// Holds byte/record FSM encodings and the expected-index helper.
package uart_rec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } byte_st_t;

    typedef enum logic [2:0] {
        HI,
        LO,
        IDX,
        T_HI,
        T_LO,
        T_PAD
    } rec_st_t;

    localparam int SAMPLE_W  = 14;
    localparam int INDEX_W   = 8;
    localparam int WAVENUM_W = 16;

    function automatic logic [INDEX_W-1:0] next_index(input logic [9:0] cnt);
        return cnt[INDEX_W-1:0] + 8'd1;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// Line synchroniser and 8N1 byte deserialiser with mid-bit sampling.
// byte_valid/frame_err are strobes on the stop-bit sample cycle.
module uart_byte_rx
    import uart_rec_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       start,
    output logic       busy,
    output logic       line
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    byte_st_t      state;
    logic          rx_m;
    logic          rx_s;
    logic          rx_p;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_i;
    logic [7:0]    sh;
    logic          stop_hit;

    assign stop_hit   = (state == STOP) && (cnt == FULL);
    assign byte_valid = stop_hit && rx_s;
    assign frame_err  = stop_hit && !rx_s;
    assign rx_byte    = sh;
    assign start      = (state == IDLE) && rx_p && !rx_s;
    assign busy       = (state != IDLE);
    assign line       = rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m  <= 1'b1;
            rx_s  <= 1'b1;
            rx_p  <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
            bit_i <= '0;
            sh    <= '0;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    bit_i <= '0;
                    if (rx_p && !rx_s)
                        state <= START;
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        sh    <= {rx_s, sh[7:1]};
                        bit_i <= bit_i + 1'b1;
                        if (bit_i == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_record_rx.sv
// Reassembles UART bytes into 14-bit sample records and a wave-number trailer.
// Optional index sequence checking is enabled by defining INDEX_CHECK_EN.
module uart_record_rx
    import uart_rec_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int RECORDS      = 1000,
    parameter int IDLE_BITS    = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    input  logic                 clear,
    output logic [SAMPLE_W-1:0]  sample_out,
    output logic [INDEX_W-1:0]   index_out,
    output logic                 sample_valid,
    output logic [WAVENUM_W-1:0] wave_number,
    output logic                 wave_valid,
    output logic [9:0]           record_count,
    output logic                 frame_err,
    output logic                 seq_err
);

    localparam int IDLE_LIM = IDLE_BITS * CLKS_PER_BIT;
    localparam int IW       = $clog2(IDLE_LIM + 1);

    logic [7:0]    b;
    logic          b_valid;
    logic          b_ferr;
    logic          b_start;
    logic          b_busy;
    logic          b_line;
    rec_st_t       rstate;
    logic [5:0]    hi_q;
    logic [7:0]    lo_q;
    logic [7:0]    wn_hi;
    logic [7:0]    wn_lo;
    logic [IW-1:0] idle_cnt;
    logic          idle_hit;
    logic          in_prog;
    logic          abort;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .rx_byte   (b),
        .byte_valid(b_valid),
        .frame_err (b_ferr),
        .start     (b_start),
        .busy      (b_busy),
        .line      (b_line)
    );

    assign idle_hit = (idle_cnt == IW'(IDLE_LIM));
    assign in_prog  = (rstate != HI) || (record_count != '0);
    assign abort    = clear || (idle_hit && in_prog);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate       <= HI;
            hi_q         <= '0;
            lo_q         <= '0;
            wn_hi        <= '0;
            wn_lo        <= '0;
            idle_cnt     <= '0;
            sample_out   <= '0;
            index_out    <= '0;
            sample_valid <= 1'b0;
            wave_number  <= '0;
            wave_valid   <= 1'b0;
            record_count <= '0;
            frame_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            wave_valid   <= 1'b0;
            frame_err    <= b_ferr;
            if (b_start || b_busy || !b_line)
                idle_cnt <= '0;
            else if (!idle_hit)
                idle_cnt <= idle_cnt + 1'b1;
            if (abort) begin
                rstate       <= HI;
                record_count <= '0;
            end else if (b_valid) begin
                case (rstate)
                    HI: begin
                        hi_q   <= b[5:0];
                        rstate <= LO;
                    end
                    LO: begin
                        lo_q   <= b;
                        rstate <= IDX;
                    end
                    IDX: begin
                        sample_out   <= {hi_q, lo_q};
                        index_out    <= b;
                        sample_valid <= 1'b1;
                        record_count <= record_count + 1'b1;
                        rstate <= (record_count == 10'(RECORDS - 1))
                                  ? T_HI : HI;
                    end
                    T_HI: begin
                        wn_hi  <= b;
                        rstate <= T_LO;
                    end
                    T_LO: begin
                        wn_lo  <= b;
                        rstate <= T_PAD;
                    end
                    T_PAD: begin
                        wave_number  <= {wn_hi, wn_lo};
                        wave_valid   <= 1'b1;
                        record_count <= '0;
                        rstate       <= HI;
                    end
                    default: rstate <= HI;
                endcase
            end
        end
    end

`ifdef INDEX_CHECK_EN
    logic seq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            seq_q <= 1'b0;
        else if (clear)
            seq_q <= 1'b0;
        else if (!abort && b_valid) begin
            if (rstate == T_PAD)
                seq_q <= 1'b0;
            else if (rstate == IDX && b != next_index(record_count))
                seq_q <= 1'b1;
        end
    end

    assign seq_err = seq_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule
